hazard_unit: RTL and testbench



---
 rtl/forwarding_unit_pkg.sv | 11 +
 rtl/hazard_unit_pkg.sv | 15 +
 rtl/hazard_unit_if.sv | 38 +++
 rtl/hazard_unit_detector.sv | 36 +++
 rtl/hazard_unit.sv | 135 +++++++++++++
 tb/tb_hazard_unit.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/forwarding_unit_pkg.sv
// rtl/forwarding_unit_pkg.sv - operand-use classes shared by forwarding and hazard logic
package forwarding_unit_pkg;

   // NoType: no register sources; Type1: ALU-style use in EX; Type2: operands needed in ID (branches)
   typedef enum logic [1:0] {
      NoType = 2'd0,
      Type1  = 2'd1,
      Type2  = 2'd2
   } forwarding_type_t;

endpackage

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - hazard unit states and register-match helper
package hazard_unit_pkg;

   typedef enum logic [1:0] {
      Run       = 2'd0,
      MemWait   = 2'd1,
      TrapFlush = 2'd2
   } hazard_state_t;

   function automatic logic reg_match(input logic used, input logic [4:0] rs,
                                      input logic [4:0] rd, input logic we);
      return used && (rs == rd) && (rd != 5'd0) && we;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-side operand/destination info and stall/flush controls
import forwarding_unit_pkg::*;

interface hazard_unit_if;
   forwarding_type_t forwarding_type_id;
   logic [4:0]       rs1_id;
   logic [4:0]       rs2_id;
   logic [4:0]       rd_ex;
   logic             reg_we_ex;
   logic             mem_rd_ex;
   logic             zicsr_ex;
   logic [4:0]       rd_mem;
   logic             reg_we_mem;
   logic             mem_rd_mem;
   logic             mem_req_mem;
   logic             mem_ack;
   logic             branch_taken_id;
   logic             trap;
   logic             stall_if;
   logic             stall_id;
   logic             stall_ex;
   logic             stall_mem;
   logic             flush_id;
   logic             flush_ex;
   logic             flush_mem;

   modport master (
      output forwarding_type_id, rs1_id, rs2_id, rd_ex, reg_we_ex, mem_rd_ex, zicsr_ex,
             rd_mem, reg_we_mem, mem_rd_mem, mem_req_mem, mem_ack, branch_taken_id, trap,
      input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem
   );

   modport slave (
      input  forwarding_type_id, rs1_id, rs2_id, rd_ex, reg_we_ex, mem_rd_ex, zicsr_ex,
             rd_mem, reg_we_mem, mem_rd_mem, mem_req_mem, mem_ack, branch_taken_id, trap,
      output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem
   );
endinterface

// File: rtl/hazard_unit_detector.sv
// rtl/hazard_unit_detector.sv - combinational load-use and branch-operand hazard detection
import forwarding_unit_pkg::*;
import hazard_unit_pkg::*;

module hazard_detector (
   input  forwarding_type_t forwarding_type_id,
   input  logic [4:0]       rs1_id,
   input  logic [4:0]       rs2_id,
   input  logic [4:0]       rd_ex,
   input  logic             reg_we_ex,
   input  logic             mem_rd_ex,
   input  logic             zicsr_ex,
   input  logic [4:0]       rd_mem,
   input  logic             reg_we_mem,
   input  logic             mem_rd_mem,
   output logic             h_load,
   output logic             h_brex,
   output logic             h_brmem
);
   logic used1, used2, is_branch;
   logic m1_ex, m2_ex, m1_mem, m2_mem;

   assign used1     = (forwarding_type_id != NoType) && (rs1_id != 5'd0);
   assign used2     = (forwarding_type_id != NoType) && (rs2_id != 5'd0);
   assign is_branch = (forwarding_type_id == Type2);

   assign m1_ex  = reg_match(used1, rs1_id, rd_ex, reg_we_ex);
   assign m2_ex  = reg_match(used2, rs2_id, rd_ex, reg_we_ex);
   assign m1_mem = reg_match(used1, rs1_id, rd_mem, reg_we_mem);
   assign m2_mem = reg_match(used2, rs2_id, rd_mem, reg_we_mem);

   assign h_load  = mem_rd_ex && (m1_ex || m2_ex);
   // A Zicsr result can reach rs1 in time from EX, but not rs2
   assign h_brex  = is_branch && (m1_ex || m2_ex) && !(zicsr_ex && m1_ex && !m2_ex);
   assign h_brmem = is_branch && mem_rd_mem && (m1_mem || m2_mem);
endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush control FSM; HAZARD_PERF_COUNTERS_EN adds stall/flush counters
import forwarding_unit_pkg::*;
import hazard_unit_pkg::*;

module hazard_unit (
   input  logic        clock,
   input  logic        reset_n,
`ifdef HAZARD_PERF_COUNTERS_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events,
`endif
   hazard_unit_if.slave hz
);
   hazard_state_t state_q, state_d;
   logic          trap_pending_q, trap_pending_d;
   logic          h_load, h_brex, h_brmem, data_hazard;
   logic          s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem;

   hazard_detector u_detector (
      .forwarding_type_id (hz.forwarding_type_id),
      .rs1_id             (hz.rs1_id),
      .rs2_id             (hz.rs2_id),
      .rd_ex              (hz.rd_ex),
      .reg_we_ex          (hz.reg_we_ex),
      .mem_rd_ex          (hz.mem_rd_ex),
      .zicsr_ex           (hz.zicsr_ex),
      .rd_mem             (hz.rd_mem),
      .reg_we_mem         (hz.reg_we_mem),
      .mem_rd_mem         (hz.mem_rd_mem),
      .h_load             (h_load),
      .h_brex             (h_brex),
      .h_brmem            (h_brmem)
   );

   assign data_hazard = h_load | h_brex | h_brmem;

   always_comb begin
      state_d        = state_q;
      trap_pending_d = trap_pending_q;
      s_if  = 1'b0;
      s_id  = 1'b0;
      s_ex  = 1'b0;
      s_mem = 1'b0;
      f_id  = 1'b0;
      f_ex  = 1'b0;
      f_mem = 1'b0;
      case (state_q)
         Run: begin
            if (hz.mem_req_mem && !hz.mem_ack) begin
               {s_if, s_id, s_ex, s_mem} = 4'b1111;
               trap_pending_d = trap_pending_q | hz.trap;
               state_d = MemWait;
            end else if (hz.trap) begin
               {f_id, f_ex, f_mem} = 3'b111;
               state_d = TrapFlush;
            end else if (data_hazard) begin
               s_if = 1'b1;
               s_id = 1'b1;
               f_ex = 1'b1;
            end else if (hz.branch_taken_id) begin
               f_id = 1'b1;
            end
         end
         MemWait: begin
            if (!hz.mem_ack) begin
               {s_if, s_id, s_ex, s_mem} = 4'b1111;
               trap_pending_d = trap_pending_q | hz.trap;
            end else begin
               trap_pending_d = 1'b0;
               if (hz.trap || trap_pending_q) begin
                  {f_id, f_ex, f_mem} = 3'b111;
                  state_d = TrapFlush;
               end else begin
                  state_d = Run;
               end
            end
         end
         TrapFlush: begin
            // Kill the fetch that raced the trap redirect
            f_id    = 1'b1;
            state_d = Run;
         end
         default: begin
            state_d        = Run;
            trap_pending_d = 1'b0;
         end
      endcase
   end

   // Outputs are held quiet while reset is asserted, whatever the inputs do
   assign hz.stall_if  = reset_n & s_if;
   assign hz.stall_id  = reset_n & s_id;
   assign hz.stall_ex  = reset_n & s_ex;
   assign hz.stall_mem = reset_n & s_mem;
   assign hz.flush_id  = reset_n & f_id;
   assign hz.flush_ex  = reset_n & f_ex;
   assign hz.flush_mem = reset_n & f_mem;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= Run;
         trap_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         trap_pending_q <= trap_pending_d;
      end
   end

`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_events_q, flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_events_d = flush_events_q;
      if (hz.stall_if)
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (hz.flush_id || hz.flush_ex || hz.flush_mem)
         flush_events_d = flush_events_q + 32'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles_q <= 32'd0;
         flush_events_q <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed table and sequence checks for hazard_unit
`timescale 1ns/1ps
import forwarding_unit_pkg::*;
import hazard_unit_pkg::*;

module tb_hazard_unit;
   logic clock;
   logic reset_n;
`ifdef HAZARD_PERF_COUNTERS_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;
`endif

   hazard_unit_if hz_if ();

   hazard_unit dut (
      .clock   (clock),
      .reset_n (reset_n),
`ifdef HAZARD_PERF_COUNTERS_EN
      .stall_cycles (stall_cycles),
      .flush_events (flush_events),
`endif
      .hz      (hz_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string            name;
      forwarding_type_t ft;
      logic [4:0]       rs1, rs2, rd_ex;
      logic             we_ex, mrd_ex, zicsr;
      logic [4:0]       rd_mem;
      logic             we_mem, mrd_mem, br;
      logic [6:0]       exp;
   } vec_t;

   // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem}
   localparam logic [6:0] O_NONE  = 7'b0000000;
   localparam logic [6:0] O_HAZ   = 7'b1100010;
   localparam logic [6:0] O_BR    = 7'b0000100;
   localparam logic [6:0] O_MEMW  = 7'b1111000;
   localparam logic [6:0] O_TRAP  = 7'b0000111;
   localparam logic [6:0] O_TFL   = 7'b0000100;

   int passed = 0;
   int total  = 0;
   vec_t vecs[16];

   function automatic vec_t mk(string n, forwarding_type_t ft, logic [4:0] rs1, logic [4:0] rs2,
                               logic [4:0] rd_ex, logic we_ex, logic mrd_ex, logic zicsr,
                               logic [4:0] rd_mem, logic we_mem, logic mrd_mem, logic br,
                               logic [6:0] exp);
      vec_t v;
      v.name = n; v.ft = ft; v.rs1 = rs1; v.rs2 = rs2; v.rd_ex = rd_ex;
      v.we_ex = we_ex; v.mrd_ex = mrd_ex; v.zicsr = zicsr; v.rd_mem = rd_mem;
      v.we_mem = we_mem; v.mrd_mem = mrd_mem; v.br = br; v.exp = exp;
      return v;
   endfunction

   function automatic logic [6:0] outs();
      return {hz_if.stall_if, hz_if.stall_id, hz_if.stall_ex, hz_if.stall_mem,
              hz_if.flush_id, hz_if.flush_ex, hz_if.flush_mem};
   endfunction

   task automatic chk(input string name, input logic [6:0] exp);
      logic [6:0] act;
      act = outs();
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic idle();
      hz_if.forwarding_type_id = NoType;
      hz_if.rs1_id = 5'd0; hz_if.rs2_id = 5'd0; hz_if.rd_ex = 5'd0;
      hz_if.reg_we_ex = 1'b0; hz_if.mem_rd_ex = 1'b0; hz_if.zicsr_ex = 1'b0;
      hz_if.rd_mem = 5'd0; hz_if.reg_we_mem = 1'b0; hz_if.mem_rd_mem = 1'b0;
      hz_if.mem_req_mem = 1'b0; hz_if.mem_ack = 1'b0;
      hz_if.branch_taken_id = 1'b0; hz_if.trap = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      hz_if.forwarding_type_id = v.ft;
      hz_if.rs1_id = v.rs1; hz_if.rs2_id = v.rs2; hz_if.rd_ex = v.rd_ex;
      hz_if.reg_we_ex = v.we_ex; hz_if.mem_rd_ex = v.mrd_ex; hz_if.zicsr_ex = v.zicsr;
      hz_if.rd_mem = v.rd_mem; hz_if.reg_we_mem = v.we_mem; hz_if.mem_rd_mem = v.mrd_mem;
      hz_if.branch_taken_id = v.br;
   endtask

   // Advance to 1ns past the next rising edge, where new inputs are driven
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int stalls;
      idle();
      reset_n = 1'b0;
      #2;
      chk("reset_outputs", O_NONE);
      #1 reset_n = 1'b1;
      step(); #1;
      chk("post_reset_idle", O_NONE);

      vecs[0]  = mk("load_use_rs1",     Type1, 5, 0, 5, 1, 1, 0, 0, 0, 0, 0, O_HAZ);
      vecs[1]  = mk("rd_zero_rs_zero",  Type1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, O_NONE);
      vecs[2]  = mk("notype_no_use",    NoType, 5, 5, 5, 1, 1, 0, 0, 0, 0, 0, O_NONE);
      vecs[3]  = mk("load_use_rs2",     Type1, 1, 9, 9, 1, 1, 0, 0, 0, 0, 0, O_HAZ);
      vecs[4]  = mk("load_no_we",       Type1, 5, 0, 5, 0, 1, 0, 0, 0, 0, 0, O_NONE);
      vecs[5]  = mk("alu_fwd_ok",       Type1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, O_NONE);
      vecs[6]  = mk("zicsr_rs1_exempt", Type2, 3, 0, 3, 1, 0, 1, 0, 0, 0, 0, O_NONE);
      vecs[7]  = mk("zicsr_rs2_stall",  Type2, 0, 3, 3, 1, 0, 1, 0, 0, 0, 0, O_HAZ);
      vecs[8]  = mk("brex_rs1",         Type2, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, O_HAZ);
      vecs[9]  = mk("zicsr_both_match", Type2, 3, 3, 3, 1, 0, 1, 0, 0, 0, 0, O_HAZ);
      vecs[10] = mk("brmem_load",       Type2, 0, 7, 0, 0, 0, 0, 7, 1, 1, 0, O_HAZ);
      vecs[11] = mk("brmem_alu_ok",     Type2, 0, 7, 0, 0, 0, 0, 7, 1, 0, 0, O_NONE);
      vecs[12] = mk("type1_mem_load",   Type1, 7, 0, 0, 0, 0, 0, 7, 1, 1, 0, O_NONE);
      vecs[13] = mk("branch_taken",     Type2, 2, 4, 6, 1, 0, 0, 8, 1, 1, 1, O_BR);
      vecs[14] = mk("branch_plus_haz",  Type1, 5, 0, 5, 1, 1, 0, 0, 0, 0, 1, O_HAZ);
      vecs[15] = mk("brmem_no_we",      Type2, 7, 0, 0, 0, 0, 0, 7, 0, 1, 0, O_NONE);

      for (int i = 0; i < 16; i++) begin
         step();
         apply(vecs[i]);
         #1;
         chk(vecs[i].name, vecs[i].exp);
      end

      // Load followed by branch dependency: exactly two stall cycles
      step(); idle(); #1;
      stalls = 0;
      step();
      hz_if.forwarding_type_id = Type2; hz_if.rs2_id = 5'd7;
      hz_if.rd_ex = 5'd7; hz_if.reg_we_ex = 1'b1; hz_if.mem_rd_ex = 1'b1;
      #1; chk("brdep_c1", O_HAZ); stalls += int'(hz_if.stall_if);
      step();
      hz_if.rd_ex = 5'd0; hz_if.reg_we_ex = 1'b0; hz_if.mem_rd_ex = 1'b0;
      hz_if.rd_mem = 5'd7; hz_if.reg_we_mem = 1'b1; hz_if.mem_rd_mem = 1'b1;
      #1; chk("brdep_c2", O_HAZ); stalls += int'(hz_if.stall_if);
      step();
      hz_if.rd_mem = 5'd0; hz_if.reg_we_mem = 1'b0; hz_if.mem_rd_mem = 1'b0;
      #1; chk("brdep_c3", O_NONE); stalls += int'(hz_if.stall_if);
      total++;
      if (stalls == 2) passed++;
      else $display("FAIL brdep_count: got %0d expected 2", stalls);

      // Memory wait with trap in cycle 2, then flush sequence
      step(); idle(); hz_if.mem_req_mem = 1'b1; #1; chk("memw_c1", O_MEMW);
      step(); hz_if.trap = 1'b1; #1; chk("memw_c2_trap", O_MEMW);
      step(); hz_if.trap = 1'b0; hz_if.branch_taken_id = 1'b1; #1; chk("memw_c3_br_ignored", O_MEMW);
      step(); hz_if.branch_taken_id = 1'b0; hz_if.mem_ack = 1'b1; #1; chk("memw_ack_flush", O_TRAP);
      step(); hz_if.mem_req_mem = 1'b0; hz_if.mem_ack = 1'b0; hz_if.branch_taken_id = 1'b1;
      #1; chk("trapflush", O_TFL);
      step(); hz_if.branch_taken_id = 1'b0; #1; chk("memw_back_run", O_NONE);

      // Trap in Run, then one-cycle TrapFlush
      step(); hz_if.trap = 1'b1; #1; chk("run_trap", O_TRAP);
      step(); hz_if.trap = 1'b0; hz_if.forwarding_type_id = Type1; hz_if.rs1_id = 5'd5;
      hz_if.rd_ex = 5'd5; hz_if.reg_we_ex = 1'b1; hz_if.mem_rd_ex = 1'b1;
      #1; chk("trapflush_ignores_haz", O_TFL);
      step(); idle(); #1; chk("trap_back_run", O_NONE);

      // Request acknowledged the same cycle: no stall
      step(); hz_if.mem_req_mem = 1'b1; hz_if.mem_ack = 1'b1; #1; chk("mem_ack_same_cycle", O_NONE);

      // Reset mid-MemWait clears the pending trap
      step(); idle(); hz_if.mem_req_mem = 1'b1; #1; chk("rst_memw_c1", O_MEMW);
      step(); hz_if.trap = 1'b1; #1; chk("rst_memw_trap", O_MEMW);
      step(); hz_if.trap = 1'b0; reset_n = 1'b0; #1; chk("rst_outputs_zero", O_NONE);
      #1 reset_n = 1'b1; #1; chk("rst_release_run_stall", O_MEMW);
      step(); hz_if.mem_ack = 1'b1; #1; chk("rst_no_pending_trap", O_NONE);
      step(); idle(); #1; chk("rst_final_idle", O_NONE);
      step(); #1; chk("rst_no_trapflush", O_NONE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
